td_line: RTL and testbench

Parametrised, clocked tapped delay line: the synchronous successor to the fixed five-tap analog delay parts used for CADR timing chains. Delays a WIDTH-bit input bus through TAPS taps spaced STEP clocks apart, all taps visible. Adds an optional inertial (glitch-rejecting) input mode, enable/freeze, synchronous flush and a selectable tap with one-cycle edge pulses. Used wherever the design needs timing strobes derived from a reference edge.

---
 rtl/td_line.sv | 103 ++++++++++
 tb/tb_td_line.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td_line.sv
// td_line: clocked tapped delay line with optional inertial input filter.
// Ports: clk, reset_n (async low), in, en, clear, inertial, sel -> taps, sel_out, sel_rise, sel_fall.
module td_line #(
  parameter int WIDTH  = 1,
  parameter int TAPS   = 5,
  parameter int STEP   = 1,
  parameter int GLITCH = 2,
  localparam int SW    = $clog2(TAPS + 1),
  localparam int CW    = $clog2(GLITCH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  inertial,
  input  logic [SW-1:0]         sel,
  output logic [TAPS*WIDTH-1:0] taps,
  output logic [WIDTH-1:0]      sel_out,
  output logic [WIDTH-1:0]      sel_rise,
  output logic [WIDTH-1:0]      sel_fall
);

  localparam int N = TAPS * STEP;
  localparam logic [CW-1:0] CMAX = CW'(GLITCH - 1);

  logic [N-1:0][WIDTH-1:0]    sr;
  logic [N-1:0][WIDTH-1:0]    sr_d;
  logic [WIDTH-1:0]           filt;
  logic [WIDTH-1:0]           filt_d;
  logic [WIDTH-1:0][CW-1:0]   cnt;
  logic [WIDTH-1:0][CW-1:0]   cnt_d;
  logic [WIDTH-1:0]           prev;
  logic [WIDTH-1:0]           src;
  logic [TAPS-1:0][WIDTH-1:0] tap_w;

  // Filter runs in both modes so a mode switch sees a current filt.
  always_comb begin
    filt_d = filt;
    cnt_d  = cnt;
    for (int c = 0; c < WIDTH; c++) begin
      if (in[c] == filt[c]) begin
        cnt_d[c] = '0;
      end else if (cnt[c] == CMAX) begin
        filt_d[c] = in[c];
        cnt_d[c]  = '0;
      end else begin
        cnt_d[c] = cnt[c] + CW'(1);
      end
    end
  end

  assign src = inertial ? filt : in;

  always_comb begin
    sr_d    = sr;
    sr_d[0] = src;
    for (int j = 1; j < N; j++) begin
      sr_d[j] = sr[j-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      filt <= '0;
      cnt  <= '0;
      prev <= '0;
    end else if (clear) begin
      sr   <= '0;
      filt <= '0;
      cnt  <= '0;
      prev <= '0;
    end else if (en) begin
      sr   <= sr_d;
      filt <= filt_d;
      cnt  <= cnt_d;
      prev <= sel_out;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      tap_w[k] = sr[(k+1)*STEP-1];
    end
  end

  assign taps = tap_w;

  // Out-of-range selects read as all zeros.
  always_comb begin
    sel_out = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (sel == SW'(k)) begin
        sel_out = tap_w[k];
      end
    end
  end

  assign sel_rise = sel_out & ~prev;
  assign sel_fall = ~sel_out & prev;

endmodule

// File: tb/tb_td_line.sv
// tb_td_line: directed checks of td_line in three parameterisations.
// Drives inputs 1 time unit after each rising edge and samples there.
module tb_td_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, en, clear, inertial;

  logic       in_a;
  logic [2:0] sel_a;
  logic [4:0] taps_a;
  logic       so_a, sr_a, sf_a;

  logic       in_b;
  logic [2:0] sel_b;
  logic [3:0] taps_b;
  logic       so_b, sr_b, sf_b;

  logic [3:0]  in_c;
  logic [2:0]  sel_c;
  logic [19:0] taps_c;
  logic [3:0]  so_c, sr_c, sf_c;

  int nvec = 0;
  int nerr = 0;

  td_line #(.WIDTH(1), .TAPS(5), .STEP(1), .GLITCH(3)) u_a (
    .clk(clk), .reset_n(reset_n), .in(in_a), .en(en), .clear(clear),
    .inertial(inertial), .sel(sel_a), .taps(taps_a), .sel_out(so_a),
    .sel_rise(sr_a), .sel_fall(sf_a));

  td_line #(.WIDTH(1), .TAPS(4), .STEP(3), .GLITCH(2)) u_b (
    .clk(clk), .reset_n(reset_n), .in(in_b), .en(en), .clear(clear),
    .inertial(inertial), .sel(sel_b), .taps(taps_b), .sel_out(so_b),
    .sel_rise(sr_b), .sel_fall(sf_b));

  td_line #(.WIDTH(4), .TAPS(5), .STEP(1), .GLITCH(2)) u_c (
    .clk(clk), .reset_n(reset_n), .in(in_c), .en(en), .clear(clear),
    .inertial(inertial), .sel(sel_c), .taps(taps_c), .sel_out(so_c),
    .sel_rise(sr_c), .sel_fall(sf_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    en       = 1'b1;
    clear    = 1'b0;
    inertial = 1'b0;
    in_a = 1'b0; in_b = 1'b0; in_c = 4'h0;
    sel_a = 3'd0; sel_b = 3'd0; sel_c = 3'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    in_a = 1'b1; in_b = 1'b1; in_c = 4'hf;
    en = 1'b1; clear = 1'b0; inertial = 1'b0;
    sel_a = 3'd0; sel_b = 3'd0; sel_c = 3'd0;
    reset_n = 1'b1;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    nvec++;
    if (taps_a !== 5'h0 || so_a !== 1'b0 || sr_a !== 1'b0 || sf_a !== 1'b0) begin
      nerr++;
      $display("FAIL reset_a got taps=%b out=%b r=%b f=%b want 0", taps_a, so_a, sr_a, sf_a);
    end
    nvec++;
    if (taps_b !== 4'h0 || so_b !== 1'b0) begin
      nerr++;
      $display("FAIL reset_b got taps=%b out=%b want 0", taps_b, so_b);
    end
    nvec++;
    if (taps_c !== 20'h0 || so_c !== 4'h0 || sr_c !== 4'h0 || sf_c !== 4'h0) begin
      nerr++;
      $display("FAIL reset_c got taps=%h out=%h want 0", taps_c, so_c);
    end
  endtask

  task automatic test_transport;
    logic [4:0] ex;
    do_reset();
    sel_a = 3'd2;
    for (int e = 1; e <= 30; e++) begin
      in_a = (e >= 10 && e < 20);
      tick();
      for (int k = 1; k <= 5; k++) ex[k-1] = (e >= 9 + k && e < 19 + k);
      nvec++;
      if (taps_a !== ex) begin
        nerr++;
        $display("FAIL transport_taps e=%0d got %b want %b", e, taps_a, ex);
      end
      nvec++;
      if (sr_a !== (e == 12)) begin
        nerr++;
        $display("FAIL transport_rise e=%0d got %b want %b", e, sr_a, (e == 12));
      end
      nvec++;
      if (sf_a !== (e == 22)) begin
        nerr++;
        $display("FAIL transport_fall e=%0d got %b want %b", e, sf_a, (e == 22));
      end
    end
  endtask

  task automatic test_step;
    logic [3:0] ex;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      in_b = (e == 5);
      tick();
      for (int k = 1; k <= 4; k++) ex[k-1] = (e == 4 + 3 * k);
      nvec++;
      if (taps_b !== ex) begin
        nerr++;
        $display("FAIL step_taps e=%0d got %b want %b", e, taps_b, ex);
      end
      nvec++;
      if (so_b !== ex[0]) begin
        nerr++;
        $display("FAIL step_sel e=%0d got %b want %b", e, so_b, ex[0]);
      end
    end
  endtask

  task automatic test_inertial;
    logic [4:0] ex;
    do_reset();
    inertial = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      in_a = (e == 5 || e == 6 || (e >= 20 && e <= 22));
      tick();
      for (int k = 1; k <= 5; k++) ex[k-1] = (e >= 22 + k && e <= 24 + k);
      nvec++;
      if (taps_a !== ex) begin
        nerr++;
        $display("FAIL inertial_taps e=%0d got %b want %b", e, taps_a, ex);
      end
      nvec++;
      if (sr_a !== (e == 23)) begin
        nerr++;
        $display("FAIL inertial_rise e=%0d got %b want %b", e, sr_a, (e == 23));
      end
    end
    inertial = 1'b0;
  endtask

  task automatic test_freeze;
    logic [4:0] ex;
    int eff;
    do_reset();
    sel_a = 3'd1;
    eff = 0;
    for (int e = 1; e <= 20; e++) begin
      in_a = (e == 5);
      en = !(e >= 7 && e <= 10);
      tick();
      if (en) eff++;
      for (int k = 1; k <= 5; k++) ex[k-1] = (eff == 4 + k);
      nvec++;
      if (taps_a !== ex) begin
        nerr++;
        $display("FAIL freeze_taps e=%0d got %b want %b", e, taps_a, ex);
      end
      nvec++;
      if (sr_a !== (e >= 6 && e <= 10)) begin
        nerr++;
        $display("FAIL freeze_rise e=%0d got %b want %b", e, sr_a, (e >= 6 && e <= 10));
      end
      nvec++;
      if (sf_a !== (e == 11)) begin
        nerr++;
        $display("FAIL freeze_fall e=%0d got %b want %b", e, sf_a, (e == 11));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_clear;
    do_reset();
    in_a = 1'b1;
    repeat (8) tick();
    nvec++;
    if (taps_a !== 5'h1f) begin
      nerr++;
      $display("FAIL clear_fill got %b want 11111", taps_a);
    end
    en = 1'b0;
    clear = 1'b1;
    tick();
    nvec++;
    if (taps_a !== 5'h0 || sf_a !== 1'b0 || sr_a !== 1'b0) begin
      nerr++;
      $display("FAIL clear_flush got taps=%b r=%b f=%b want 0", taps_a, sr_a, sf_a);
    end
    clear = 1'b0;
    en = 1'b1;
    in_a = 1'b0;
    tick();
    nvec++;
    if (taps_a !== 5'h0 || sf_a !== 1'b0 || sr_a !== 1'b0) begin
      nerr++;
      $display("FAIL clear_after got taps=%b r=%b f=%b want 0", taps_a, sr_a, sf_a);
    end
    in_a = 1'b1;
    repeat (6) tick();
    nvec++;
    if (taps_a !== 5'h1f || so_a !== 1'b1) begin
      nerr++;
      $display("FAIL refill got taps=%b out=%b want 11111/1", taps_a, so_a);
    end
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (taps_a !== 5'h0 || so_a !== 1'b0 || sr_a !== 1'b0 || sf_a !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset got taps=%b out=%b r=%b f=%b want 0", taps_a, so_a, sr_a, sf_a);
    end
    in_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    nvec++;
    if (taps_a !== 5'h0 || sr_a !== 1'b0 || sf_a !== 1'b0) begin
      nerr++;
      $display("FAIL post_reset got taps=%b r=%b f=%b want 0", taps_a, sr_a, sf_a);
    end
  endtask

  task automatic test_sel_bound;
    do_reset();
    sel_a = 3'd5;
    in_a = 1'b1;
    repeat (6) tick();
    nvec++;
    if (so_a !== 1'b0 || sr_a !== 1'b0) begin
      nerr++;
      $display("FAIL sel_range got out=%b r=%b want 0/0", so_a, sr_a);
    end
    sel_a = 3'd0;
    #1;
    nvec++;
    if (so_a !== 1'b1 || sr_a !== 1'b1) begin
      nerr++;
      $display("FAIL sel_switch got out=%b r=%b want 1/1", so_a, sr_a);
    end
    tick();
    nvec++;
    if (sr_a !== 1'b0) begin
      nerr++;
      $display("FAIL sel_once got r=%b want 0", sr_a);
    end
    sel_a = 3'd7;
    #1;
    nvec++;
    if (so_a !== 1'b0 || sf_a !== 1'b1) begin
      nerr++;
      $display("FAIL sel_max got out=%b f=%b want 0/1", so_a, sf_a);
    end
    tick();
    nvec++;
    if (sf_a !== 1'b0) begin
      nerr++;
      $display("FAIL sel_max_once got f=%b want 0", sf_a);
    end
  endtask

  task automatic test_channels;
    logic [3:0]  vec [12];
    logic [19:0] ex;
    logic [3:0]  cur, prv;
    int idx;
    vec = '{4'h1, 4'h3, 4'h2, 4'h6, 4'hf, 4'h0,
            4'h9, 4'ha, 4'h5, 4'hc, 4'h7, 4'h8};
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      in_c = (e - 1 < 12) ? vec[e-1] : 4'h0;
      tick();
      for (int k = 1; k <= 5; k++) begin
        idx = e - k;
        ex[(k-1)*4 +: 4] = (idx >= 0 && idx < 12) ? vec[idx] : 4'h0;
      end
      cur = ex[3:0];
      idx = e - 2;
      prv = (idx >= 0 && idx < 12) ? vec[idx] : 4'h0;
      nvec++;
      if (taps_c !== ex) begin
        nerr++;
        $display("FAIL chan_taps e=%0d got %h want %h", e, taps_c, ex);
      end
      nvec++;
      if (sr_c !== (cur & ~prv) || sf_c !== (~cur & prv)) begin
        nerr++;
        $display("FAIL chan_edges e=%0d got r=%b f=%b want r=%b f=%b",
                 e, sr_c, sf_c, cur & ~prv, ~cur & prv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transport();
    test_step();
    test_inertial();
    test_freeze();
    test_clear();
    test_sel_bound();
    test_channels();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
